// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : RV32I instruction fetch stage. Owns the program counter,
//               drives the synchronous BIOS/IMEM read ports and presents one
//               instruction word per cycle, with its PC, to decode. Squashed
//               slots (reset, taken redirect) emit a canonical NOP, and the
//               presented word is held stable while downstream stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [11:0] bios_addr_o,
  output logic [13:0] imem_addr_o,
  input  logic [31:0] bios_dout_i,
  input  logic [31:0] imem_dout_i,
  output logic [31:0] pc_f_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o
);

  localparam logic [31:0] c_PC_STEP = 32'd4;

  // Fetch-side state
  logic [31:0] pc_f_q,      pc_f_d;
  logic [31:0] pc_d_q,      pc_d_d;
  logic        kill_q,      kill_d;
  logic        held_q,      held_d;
  logic [31:0] inst_hold_q, inst_hold_d;

  // Combinational helpers
  logic        w_advance;
  logic [31:0] w_target;
  logic [31:0] w_mem_word;
  logic        w_unused_bits;

  // The two low bits of a redirect target are forced to zero, so they are
  // intentionally not consumed anywhere else.
  assign w_unused_bits = ^redirect_pc_i[1:0];
  assign w_target      = {redirect_pc_i[31:2], 2'b00};

  // The pipeline moves forward unless stalled; a redirect always moves it.
  assign w_advance = redirect_i | ~stall_i;

  // Memory address ports follow the fetch PC unconditionally. During a stall
  // memory re-reads mem[pc_f], which is harmless because the output then
  // comes from the hold register.
  assign bios_addr_o = pc_f_q[13:2];
  assign imem_addr_o = pc_f_q[15:2];
  assign pc_f_o      = pc_f_q;

  // Bit 30 of the PC distinguishes the BIOS window from IMEM.
  assign w_mem_word = pc_d_q[30] ? bios_dout_i : imem_dout_i;

  // Output mux: squash beats hold, hold beats live memory data.
  always_comb begin
    inst_o       = w_mem_word;
    inst_valid_o = 1'b1;
    if (kill_q) begin
      inst_o       = NOP_INST;
      inst_valid_o = 1'b0;
    end else if (held_q) begin
      inst_o       = inst_hold_q;
    end
  end

  assign inst_pc_o = pc_d_q;

  // Next-state: redirect beats stall, otherwise advance sequentially.
  always_comb begin
    pc_f_d      = pc_f_q;
    pc_d_d      = pc_d_q;
    kill_d      = kill_q;
    held_d      = 1'b0;
    inst_hold_d = inst_hold_q;

    if (redirect_i) begin
      pc_f_d = w_target;
    end else if (!stall_i) begin
      pc_f_d = pc_f_q + c_PC_STEP;
    end

    // pc_d and kill move in lock-step with pc_f; under a plain stall they
    // hold, which also keeps a pending kill slot squashed.
    if (w_advance) begin
      pc_d_d = pc_f_q;
      kill_d = redirect_i;
    end

    // Capture whatever is presented now so it can be replayed while stalled.
    if (stall_i && !redirect_i) begin
      held_d      = 1'b1;
      inst_hold_d = inst_o;
    end
  end

  // State register with synchronous reset; reset wins over stall/redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_f_q      <= RESET_PC;
      pc_d_q      <= 32'd0;
      kill_q      <= 1'b1;
      held_q      <= 1'b0;
      inst_hold_q <= 32'd0;
    end else begin
      pc_f_q      <= pc_f_d;
      pc_d_q      <= pc_d_d;
      kill_q      <= kill_d;
      held_q      <= held_d;
      inst_hold_q <= inst_hold_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch
// Description : Self-checking bench for inst_fetch. Models the synchronous
//               BIOS/IMEM read ports, applies a vector table plus a short
//               hand-written sequence, and compares every cycle through an
//               expected-result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

  localparam logic [31:0] c_RESET_PC = 32'h4000_0000;
  localparam logic [31:0] c_NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [11:0] bios_addr;
  logic [13:0] imem_addr;
  logic [31:0] bios_dout;
  logic [31:0] imem_dout;
  logic [31:0] pc_f;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;

  logic [31:0] bios_mem [4096];
  logic [31:0] imem_mem [16384];

  int n_checks = 0;
  int n_pass   = 0;

  inst_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .stall_i      (stall),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .bios_addr_o  (bios_addr),
    .imem_addr_o  (imem_addr),
    .bios_dout_i  (bios_dout),
    .imem_dout_i  (imem_dout),
    .pc_f_o       (pc_f),
    .inst_o       (inst),
    .inst_pc_o    (inst_pc),
    .inst_valid_o (inst_valid)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory models: data valid one cycle after address.
  always @(posedge clk) begin
    bios_dout <= bios_mem[bios_addr];
    imem_dout <= imem_mem[imem_addr];
  end

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic        chk_pcf;
    logic [31:0] exp_pcf;
  } vec_t;

  typedef struct {
    int          idx;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        chk_pcf;
    logic [31:0] pcf;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic r, input logic s, input logic d,
                              input logic [31:0] rpc, input logic v,
                              input logic [31:0] epc, input logic cp,
                              input logic [31:0] epcf);
    vec_t t;
    t.rst = r; t.stall = s; t.redir = d; t.rpc = rpc;
    t.exp_valid = v; t.exp_pc = epc; t.chk_pcf = cp; t.exp_pcf = epcf;
    return t;
  endfunction

  // Word the memory system holds at a byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    logic [31:0] w;
    if (pc[30]) w = bios_mem[pc[13:2]];
    else        w = imem_mem[pc[15:2]];
    return w;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s vec%0d: got %h, expected %h", name, idx, act, req);
  endtask

  // Drive one cycle of stimulus, queue its expectation, then compare after
  // the edge that consumes it.
  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    exp_t got;
    rst = v.rst; stall = v.stall; redirect = v.redir; redirect_pc = v.rpc;
    e.idx = idx; e.valid = v.exp_valid; e.pc = v.exp_pc;
    e.inst = v.exp_valid ? mem_word(v.exp_pc) : c_NOP;
    e.chk_pcf = v.chk_pcf; e.pcf = v.exp_pcf;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check("inst",       got.idx, inst,    got.inst);
    check("inst_pc",    got.idx, inst_pc, got.pc);
    check("inst_valid", got.idx, {31'd0, inst_valid}, {31'd0, got.valid});
    if (got.chk_pcf) begin
      check("pc_f",      got.idx, pc_f, got.pcf);
      check("imem_addr", got.idx, {18'd0, imem_addr}, {18'd0, got.pcf[15:2]});
      check("bios_addr", got.idx, {20'd0, bios_addr}, {20'd0, got.pcf[13:2]});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4096; i++)  bios_mem[i] = 32'hB100_0000 + i;
    for (int i = 0; i < 16384; i++) imem_mem[i] = 32'hC000_0000 | i;
    bios_mem[0] = 32'h0020_0013;
    bios_mem[1] = 32'h0081_00E7;

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;

    //                rst  stl  red  redirect_pc    vld  inst_pc        chk  pc_f
    // reset / boot
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,         1'b0,32'h0,         1'b1,c_RESET_PC));
    vecs.push_back(mk(1'b1,1'b0,1'b0,32'h0,         1'b0,32'h0,         1'b1,c_RESET_PC));
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,         1'b1,32'h4000_0000, 1'b1,32'h4000_0004));
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,         1'b1,32'h4000_0004, 1'b0,32'h0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,         1'b1,32'h4000_0008, 1'b1,32'h4000_000C));
    // three-cycle stall at 0x4000_0008
    vecs.push_back(mk(1'b0,1'b1,1'b0,32'h0,         1'b1,32'h4000_0008, 1'b1,32'h4000_000C));
    vecs.push_back(mk(1'b0,1'b1,1'b0,32'h0,         1'b1,32'h4000_0008, 1'b0,32'h0));
    vecs.push_back(mk(1'b0,1'b1,1'b0,32'h0,         1'b1,32'h4000_0008, 1'b1,32'h4000_000C));
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,         1'b1,32'h4000_000C, 1'b1,32'h4000_0010));
    // redirect into IMEM
    vecs.push_back(mk(1'b0,1'b0,1'b1,32'h1000_0010, 1'b0,32'h4000_0010, 1'b1,32'h1000_0010));
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,         1'b1,32'h1000_0010, 1'b1,32'h1000_0014));
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,         1'b1,32'h1000_0014, 1'b0,32'h0));
    // back to BIOS to reach inst_pc 0x4000_0010
    vecs.push_back(mk(1'b0,1'b0,1'b1,32'h4000_000C, 1'b0,32'h1000_0018, 1'b1,32'h4000_000C));
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,         1'b1,32'h4000_000C, 1'b0,32'h0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,         1'b1,32'h4000_0010, 1'b1,32'h4000_0014));
    // redirect + stall together, then stall alone holds the kill slot
    vecs.push_back(mk(1'b0,1'b1,1'b1,32'h4000_0100, 1'b0,32'h4000_0014, 1'b1,32'h4000_0100));
    vecs.push_back(mk(1'b0,1'b1,1'b0,32'h0,         1'b0,32'h4000_0014, 1'b1,32'h4000_0100));
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,         1'b1,32'h4000_0100, 1'b1,32'h4000_0104));
    // misaligned target
    vecs.push_back(mk(1'b0,1'b0,1'b1,32'h4000_0023, 1'b0,32'h4000_0104, 1'b1,32'h4000_0020));
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,         1'b1,32'h4000_0020, 1'b1,32'h4000_0024));
    // PC wrap from 0xFFFF_FFFC to 0
    vecs.push_back(mk(1'b0,1'b0,1'b1,32'hFFFF_FFFC, 1'b0,32'h4000_0024, 1'b1,32'hFFFF_FFFC));
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,         1'b1,32'hFFFF_FFFC, 1'b1,32'h0));
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,         1'b1,32'h0,         1'b1,32'h4));
    // reset during stall (held register loaded)
    vecs.push_back(mk(1'b0,1'b1,1'b0,32'h0,         1'b1,32'h0,         1'b1,32'h4));
    vecs.push_back(mk(1'b1,1'b1,1'b0,32'h0,         1'b0,32'h0,         1'b1,c_RESET_PC));
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,         1'b1,32'h4000_0000, 1'b1,32'h4000_0004));
    vecs.push_back(mk(1'b0,1'b0,1'b0,32'h0,         1'b1,32'h4000_0004, 1'b1,32'h4000_0008));

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // Hand-written: stall begins right after a redirect's kill slot ends,
    // released word must be the target word, then reset mid-redirect.
    apply(100, mk(1'b0,1'b0,1'b1,32'h1000_0100, 1'b0,32'h4000_0008, 1'b1,32'h1000_0100));
    apply(101, mk(1'b0,1'b0,1'b0,32'h0,         1'b1,32'h1000_0100, 1'b1,32'h1000_0104));
    apply(102, mk(1'b0,1'b1,1'b0,32'h0,         1'b1,32'h1000_0100, 1'b1,32'h1000_0104));
    apply(103, mk(1'b0,1'b1,1'b0,32'h0,         1'b1,32'h1000_0100, 1'b1,32'h1000_0104));
    apply(104, mk(1'b0,1'b0,1'b0,32'h0,         1'b1,32'h1000_0104, 1'b1,32'h1000_0108));
    apply(105, mk(1'b1,1'b0,1'b1,32'h1000_0200, 1'b0,32'h0,         1'b1,c_RESET_PC));
    apply(106, mk(1'b0,1'b0,1'b0,32'h0,         1'b1,32'h4000_0000, 1'b1,32'h4000_0004));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch stage for the RV32I CPU. Owns the program counter, drives the synchronous BIOS and IMEM read ports, and presents one instruction word per cycle, with its PC, to the decode/control logic directly downstream. Squashed instructions, from reset or a taken branch/jump redirect, are replaced by a canonical NOP. The stage holds its output stable while the pipeline is stalled.

## Interface
- RESET_PC, 32'h4000_0000, PC fetched first after reset (BIOS base)
- NOP_INST, 32'h0000_0013, word emitted for squashed slots (addi x0,x0,0)
- clk  in  1  rising-edge clock, single domain
- rst  in  1  synchronous, active-high reset
- stall  in  1  downstream not accepting; hold PC and output
- redirect  in  1  taken branch/jal/jalr this cycle
- redirect_pc  in  32  target of the redirect; bits [1:0] ignored (treated as 0)
- bios_addr  out  12  BIOS word address = pc_f[13:2]
- imem_addr  out  14  IMEM word address = pc_f[15:2]
- bios_dout  in  32  BIOS read data, valid 1 cycle after address
- imem_dout  in  32  IMEM read data, valid 1 cycle after address
- pc_f  out  32  address currently being fetched
- inst  out  32  instruction to decode/control
- inst_pc  out  32  PC of `inst`
- inst_valid  out  1  0 when `inst` is a squash NOP

## Operation
- Registers:
  - pc_f: fetch address.
  - pc_d: PC of the word arriving from memory.
  - kill_q: squash the arriving word.
  - held_q: output comes from the hold register.
  - inst_hold: 32-bit hold register.
- Next pc_f, in priority order:
  - rst → RESET_PC.
  - redirect → {redirect_pc[31:2], 2'b00}.
  - stall → pc_f.
  - otherwise → pc_f + 4, mod 2^32; wrap from 0xFFFF_FFFC to 0 is permitted.
- pc_d and kill_q:
  - They update whenever pc_f updates: pc_d <= pc_f.
  - kill_q <= redirect | rst.
  - Under stall without redirect, both hold.
- Memory select: pc_d[30] = 1 selects bios_dout; otherwise imem_dout. Address ports are driven from pc_f unconditionally.
- Output mux, in priority order:
  - kill_q → NOP_INST, inst_valid = 0.
  - held_q → inst_hold, inst_valid = 1.
  - otherwise → the selected dout, inst_valid = 1.
- inst_pc = pc_d in all cases.
- Hold register:
  - Each cycle with stall = 1 and redirect = 0: inst_hold <= current inst and held_q <= 1.
  - Otherwise held_q <= 0.
  - Memory keeps reading mem[pc_f] during a stall. This is harmless because the output comes from inst_hold.
- Redirect beats stall:
  - A redirect during a stall clears held_q and loads the target.
  - The next output is a NOP.
- Stall during a kill slot:
  - The NOP is held, kill_q stays 1 and inst_valid stays 0.
  - The target fetch is not lost because pc_f holds the target.

## Timing
- Reset (cycle after rst sampled high):
  - pc_f = RESET_PC, pc_d = 0, kill_q = 1, held_q = 0, inst_hold = 0.
  - inst = NOP_INST, inst_valid = 0, inst_pc = 0.
- First valid instruction: mem[RESET_PC] appears on inst 2 cycles after rst deasserts (one kill slot, then data).
- Steady state: one instruction per cycle; inst_pc increments by 4.
- Redirect penalty:
  - Redirect sampled in cycle n.
  - Cycle n+1: NOP, inst_valid = 0.
  - Cycle n+2: mem[target] with inst_pc = target.
- Stall:
  - Stall sampled high in cycles n..n+k-1: inst and inst_pc are unchanged in cycles n+1..n+k.
  - Cycle n+k+1 presents the next sequential word.
- rst mid-stall or mid-redirect: reset wins; state is as in reset above.

## Test plan
- Reset/boot:
  - Stimulus: rst high 2 cycles, BIOS[0] = 0x00200013, BIOS[1] = 0x008100E7.
  - Required: cycle 1 after release gives inst_valid = 0 and inst = 0x13.
  - Cycle 2 gives inst = 0x00200013, inst_pc = 0x4000_0000.
  - Cycle 3 gives 0x008100E7, inst_pc = 0x4000_0004.
- Stall:
  - Stimulus: stall for 3 cycles while inst_pc = 0x4000_0008.
  - Required: inst and inst_pc frozen for 3 cycles; next cycle inst_pc = 0x4000_000C with the correct word.
- Redirect to IMEM:
  - Stimulus: redirect = 1, redirect_pc = 0x1000_0010.
  - Required: the next cycle gives a NOP with valid 0 and imem_addr = 0x004.
  - The following cycle gives inst = IMEM[4], inst_pc = 0x1000_0010.
- Redirect and stall together:
  - Stimulus: both asserted at inst_pc = 0x4000_0010, target 0x4000_0100.
  - Required: NOP next cycle; stall then dropped gives inst_pc = 0x4000_0100.
- Misaligned target:
  - Stimulus: redirect_pc = 0x4000_0023.
  - Required: pc_f = 0x4000_0020 and inst_pc = 0x4000_0020.
- Reset during stall:
  - Stimulus: rst asserted while stall = 1 and held_q = 1.
  - Required: next cycle gives pc_f = RESET_PC, inst_valid = 0, held_q = 0.
